data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory interface. The pipeline initiates
//  48-bit vector and 32-bit scalar load/store requests. This block accepts them
//  over a valid/ready handshake and services them from an internal word array.
//  It returns read data or a write acknowledge over a second valid/ready channel.
//  It raises stall to freeze the pipeline while a request is outstanding.
// PARAMETERS
//  ADDR_W  16    request address width; addresses 48-bit words
//  DATA_W  48    word width (vector register width)
//  SCL_W   32    scalar width; occupies bits [SCL_W-1:0] of a word
//  DEPTH   1024  number of words; valid addresses are 0..DEPTH-1
//  RD_LAT  2     read latency in cycles from accept to rsp_valid; must be >=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when valid&ready
//  req_we     in   1       1=store, 0=load
//  req_vec    in   1       1=full DATA_W access, 0=scalar SCL_W access
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  store data; scalar stores use [SCL_W-1:0] only
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       response consumed when valid&ready
//  rsp_rdata  out  DATA_W  load data; 0 for stores and errors
//  rsp_err    out  1       address was >= DEPTH
//  stall      out  1       req_valid&~req_ready, or state!=IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, stall=0, latency counter=0. Array contents are not reset.
//  FSM states and transitions:
//   IDLE -> WAIT on an accepted load when RD_LAT>1.
//   IDLE -> RESP on an accepted load when RD_LAT==1, or on an accepted store.
//   WAIT -> RESP after RD_LAT-1 cycles in WAIT.
//   RESP -> IDLE on rsp_valid&rsp_ready.
//  req_ready=1 only in IDLE. One request is outstanding at most; there is no
//   overlap. req_* fields are sampled only in the accept cycle.
//  Store accepted at cycle T: the array is written at the T edge.
//   rsp_valid=1 from T+1 with rdata=0.
//   A scalar store writes bits [SCL_W-1:0]; bits [DATA_W-1:SCL_W] keep their
//   old value.
//  Load accepted at cycle T: rsp_valid=1 from T+RD_LAT.
//   Vector load: rdata = the word. Scalar load: rdata = {zeros, word[SCL_W-1:0]}.
//   rdata is registered on entry to RESP and held stable while rsp_ready=0.
//  Out of range (addr >= DEPTH): no array write. The response arrives with the
//   normal latency, with rsp_err=1 and rdata=0.
//  rsp_valid/rdata/err are held until the handshake. They drop in the cycle
//   after it, and req_ready rises in that same cycle.
//  A load at cycle T+1 after a store at T to the same address returns the new data.
//  Reset mid-operation: the outstanding request is dropped with no response.
//   A store already accepted stays committed.
// TESTING
//  1 vec store addr 5 = 48'hA1B2_C3D4_E5F6, then vec load addr 5
//    -> store rsp at T+1 with err=0; load rdata=48'hA1B2_C3D4_E5F6 at T+2.
//  2 vec store addr 7 = 48'hFFFF_0000_0000, scalar store addr 7 = 32'h1234_5678,
//    then vec load -> 48'hFFFF_1234_5678; scalar load -> 48'h0000_1234_5678.
//  3 load addr 1024 with DEPTH=1024 -> rsp_err=1, rdata=0; a later load of
//    addr 0 is unaffected and has err=0.
//  4 load with rsp_ready=0 for 5 cycles -> rsp_valid and rdata are stable, stall=1,
//    req_ready=0; the next request is accepted 1 cycle after the handshake.
//  5 rst low during WAIT -> rsp_valid never asserts, req_ready=1 at once;
//    a prior store is still readable after reset.
//  6 RD_LAT=1 and RD_LAT=4 builds -> load rsp_valid at exactly T+1 and T+4.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder for MEM-stage data-memory requests: accepts one vector/scalar load or
// store at a time, services it from an internal word array, and returns data/ack.
module data_mem_responder #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 48,
    parameter int unsigned SCL_W  = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_vec,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam int unsigned WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              vec_q, vec_d;
    logic              err_q, err_d;
    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              stall_d;

    logic              accept_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [DATA_W-1:0] rd_word_c;
    logic              sel_vec_c;
    logic              sel_err_c;
    logic [DATA_W-1:0] ld_data_c;

    assign accept_c   = req_valid & req_ready;
    assign in_range_c = (req_addr < ADDR_W'(DEPTH));
    assign req_idx_c  = req_addr[IDX_W-1:0];

    // RD_LAT==1 loads read straight from the request; longer latencies use the latched fields
    assign rd_idx_c  = (state_q == IDLE) ? req_idx_c : addr_q;
    assign sel_vec_c = (state_q == IDLE) ? req_vec : vec_q;
    assign sel_err_c = (state_q == IDLE) ? ~in_range_c : err_q;
    assign rd_word_c = mem[rd_idx_c];
    assign ld_data_c = sel_err_c ? '0 :
                       sel_vec_c ? rd_word_c : DATA_W'(rd_word_c[SCL_W-1:0]);

    // Array write at the accept edge; a scalar store leaves the upper bits untouched
    always_ff @(posedge clk) begin
        if (rst && accept_c && req_we && in_range_c) begin
            if (req_vec) begin
                mem[req_idx_c] <= req_wdata;
            end else begin
                mem[req_idx_c][SCL_W-1:0] <= req_wdata[SCL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            vec_q     <= 1'b0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            stall     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            stall     <= stall_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        vec_d       = vec_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d = req_idx_c;
                    vec_d  = req_vec;
                    err_d  = ~in_range_c;
                    cnt_d  = '0;
                    if (req_we) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = ~in_range_c;
                    end else if (RD_LAT == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_data_c;
                        rsp_err_d   = ~in_range_c;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_data_c;
                    rsp_err_d   = err_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase

        // Only IDLE accepts; any other state means a request is outstanding
        req_ready_d = (state_d == IDLE);
        stall_d     = (state_d != IDLE);
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed loads/stores, back-pressure,
// mid-operation reset, and latency checks on RD_LAT=1 and RD_LAT=4 instances.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_vec, rsp_ready;
    logic [15:0] req_addr;
    logic [47:0] req_wdata;
    logic        req_ready, rsp_valid, rsp_err, stall;
    logic [47:0] rsp_rdata;

    logic        x_req_valid, x_req_we, x_req_vec;
    logic [15:0] x_req_addr;
    logic [47:0] x_req_wdata;
    logic        x1_req_ready, x1_rsp_valid, x1_rsp_err, x1_stall;
    logic        x4_req_ready, x4_rsp_valid, x4_rsp_err, x4_stall;
    logic [47:0] x1_rsp_rdata, x4_rsp_rdata;

    typedef struct {
        logic [47:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .stall(stall)
    );

    data_mem_responder #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(x_req_valid), .req_ready(x1_req_ready),
        .req_we(x_req_we), .req_vec(x_req_vec), .req_addr(x_req_addr), .req_wdata(x_req_wdata),
        .rsp_valid(x1_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(x1_rsp_rdata),
        .rsp_err(x1_rsp_err), .stall(x1_stall)
    );

    data_mem_responder #(.RD_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .req_valid(x_req_valid), .req_ready(x4_req_ready),
        .req_we(x_req_we), .req_vec(x_req_vec), .req_addr(x_req_addr), .req_wdata(x_req_wdata),
        .rsp_valid(x4_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(x4_rsp_rdata),
        .rsp_err(x4_rsp_err), .stall(x4_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compares each response against the queue head; latency checked on the rising valid
    task automatic monitor();
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b0;
            end else begin
                if (rsp_valid && !prev) begin
                    if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                    else chk("rsp_latency", 64'(cyc - accept_cyc), 64'(sb[0].lat));
                end
                if (rsp_valid && rsp_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                prev = rsp_valid;
            end
        end
    endtask

    task automatic issue(input logic we, input logic vec, input logic [15:0] addr,
                         input logic [47:0] wd, input logic [47:0] er, input logic ee,
                         input bit push);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_vec   = vec;
        req_addr  = addr;
        req_wdata = wd;
        accept_cyc = cyc;
        if (push) sb.push_back('{er, ee, (we ? 1 : 2)});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, l1, l4;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        x_req_valid = 1'b0; x_req_we = 1'b0; x_req_vec = 1'b0; x_req_addr = '0; x_req_wdata = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Vector store then load
        issue(1'b1, 1'b1, 16'd5, 48'hA1B2_C3D4_E5F6, 48'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 16'd5, 48'h0, 48'hA1B2_C3D4_E5F6, 1'b0, 1'b1);

        // Scalar store merges into the low 32 bits only
        issue(1'b1, 1'b1, 16'd7, 48'hFFFF_0000_0000, 48'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 16'd7, 48'hDEAD_1234_5678, 48'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 16'd7, 48'h0, 48'hFFFF_1234_5678, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 16'd7, 48'h0, 48'h0000_1234_5678, 1'b0, 1'b1);

        // Range boundary: 1023 valid, 1024 and 1029 (aliases index 5) rejected
        issue(1'b1, 1'b1, 16'd0, 48'h1111_2222_3333, 48'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 16'd1024, 48'h0, 48'h0, 1'b1, 1'b1);
        issue(1'b0, 1'b1, 16'd0, 48'h0, 48'h1111_2222_3333, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 16'd1029, 48'h5555_5555_5555, 48'h0, 1'b1, 1'b1);
        issue(1'b0, 1'b1, 16'd5, 48'h0, 48'hA1B2_C3D4_E5F6, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 16'd1023, 48'h7777_8888_9999, 48'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 16'd1023, 48'h0, 48'h0000_8888_9999, 1'b0, 1'b1);
        drain();

        // Back-pressure: response held for 5 cycles, then next request accepted 1 cycle later
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 1'b1, 16'd7, 48'h0, 48'hFFFF_1234_5678, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'hFFFF_1234_5678);
            chk("hold_stall", 64'(stall), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_vec = 1'b1; req_addr = 16'd5;
        accept_cyc = cyc + 1;
        sb.push_back('{48'hA1B2_C3D4_E5F6, 1'b0, 2});
        @(negedge clk);
        chk("handshake_cycle_req_ready", 64'(req_ready), 64'd0);
        chk("handshake_cycle_stall", 64'(stall), 64'd1);
        @(negedge clk);
        chk("post_handshake_req_ready", 64'(req_ready), 64'd1);
        chk("post_handshake_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("accepted_req_ready", 64'(req_ready), 64'd0);
        drain();

        // Reset during WAIT drops the load; the earlier store survives
        issue(1'b1, 1'b1, 16'd9, 48'h0123_4567_89AB, 48'h0, 1'b0, 1'b1);
        drain();
        issue(1'b0, 1'b1, 16'd9, 48'h0, 48'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midreset_req_ready", 64'(req_ready), 64'd1);
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("dropped_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        issue(1'b0, 1'b1, 16'd9, 48'h0, 48'h0123_4567_89AB, 1'b0, 1'b1);
        drain();

        // RD_LAT=1 and RD_LAT=4 instances: load response latency
        @(posedge clk); #1;
        x_req_valid = 1'b1; x_req_we = 1'b1; x_req_vec = 1'b1;
        x_req_addr = 16'd3; x_req_wdata = 48'hCAFE_F00D_BEEF;
        @(posedge clk); #1;
        x_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("lat1_idle_ready", 64'(x1_req_ready), 64'd1);
        chk("lat4_idle_ready", 64'(x4_req_ready), 64'd1);
        x_req_valid = 1'b1; x_req_we = 1'b0; x_req_vec = 1'b1; x_req_addr = 16'd3;
        t0 = cyc;
        l1 = -1;
        l4 = -1;
        @(posedge clk); #1;
        x_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (l1 < 0 && x1_rsp_valid) begin
                l1 = cyc - t0;
                chk("lat1_rdata", 64'(x1_rsp_rdata), 64'hCAFE_F00D_BEEF);
                chk("lat1_err", 64'(x1_rsp_err), 64'd0);
            end
            if (l4 < 0 && x4_rsp_valid) begin
                l4 = cyc - t0;
                chk("lat4_rdata", 64'(x4_rsp_rdata), 64'hCAFE_F00D_BEEF);
                chk("lat4_stall", 64'(x4_stall), 64'd1);
            end
        end
        chk("lat1_latency", 64'(l1), 64'd1);
        chk("lat4_latency", 64'(l4), 64'd4);
        chk("lat1_stall_idle", 64'(x1_stall), 64'd0);
        chk("lat4_err", 64'(x4_rsp_err), 64'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
